stack_mem_arbiter: RTL and testbench
====================================

# stack_mem_arbiter

Shares the processor's single-port data/instruction memory between the instruction-fetch requester (driven by the multicycle controller's IR-load step) and the operand-stack requester (push/pop from the controller). Owns the stack pointer: converts push/pop into memory addresses and detects overflow/underflow. Arbitrates round-robin when both requesters are pending, and sequences the one-cycle-latency synchronous memory read.

## Interface
- ADDR_W, 5, memory address width
- DATA_W, 8, memory data width
- STACK_BASE, 31, address of the first stack slot; the stack grows downward
- STACK_DEPTH, 8, maximum number of stack entries (≤ 2^ADDR_W)
- clk  in  1  clock, rising edge
- rst  in  1  reset: asynchronous, active-high
- f_req  in  1  fetch request, held until f_gnt
- f_addr  in  ADDR_W  fetch address, stable while f_req high
- f_gnt  out  1  fetch accepted (one-cycle pulse)
- f_rdata  out  DATA_W  fetched word, valid with f_valid
- f_valid  out  1  fetch data-return pulse
- s_push  in  1  push request, held until s_gnt
- s_pop  in  1  pop request, held until s_gnt
- s_wdata  in  DATA_W  push data
- s_gnt  out  1  stack request accepted (one-cycle pulse)
- s_rdata  out  DATA_W  popped word, valid with s_valid
- s_valid  out  1  pop data-return pulse
- s_full  out  1  count == STACK_DEPTH
- s_empty  out  1  count == 0
- s_err  out  1  sticky protocol/overflow/underflow flag, cleared only by rst
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_re

## Operation
- State machine states: IDLE, F_RD, S_RD. Registers: count (0..STACK_DEPTH), prio (0 = fetch favoured), sticky err.
- IDLE: if only one requester is pending, grant it. If both are pending, grant the prio side. The grant, memory strobe, address and write data are driven combinationally in this cycle.
- After a fetch grant, prio becomes 1. After a stack grant, prio becomes 0.
- Fetch grant: mem_re=1, mem_addr=f_addr. Next state F_RD.
- Push grant (not full): mem_we=1, mem_addr=STACK_BASE−count, mem_wdata=s_wdata. count increments. State stays IDLE.
- Pop grant (not empty): mem_re=1, mem_addr=STACK_BASE−(count−1). count decrements. Next state S_RD.
- F_RD / S_RD: capture mem_rdata into f_rdata / s_rdata. Return to IDLE. No grant is issued in these states.
- Push while full: s_gnt=1, no memory access, count unchanged, err set.
- Pop while empty: s_gnt=1, no memory access, count unchanged, err set. Next cycle s_valid=1 with s_rdata=0.
- s_push and s_pop both high: treated as a stack request. s_gnt=1, no memory access, count unchanged, err set.
- Address arithmetic is modulo 2^ADDR_W. Fetch addresses are not checked against the stack region.

## Timing
- Reset values: all outputs 0, except s_empty=1. State IDLE, count 0, prio 0.
- Reset mid-read: the pending data return is discarded. No valid pulse is produced after rst deasserts.
- Fetch: grant at cycle T, mem_rdata sampled at T+1, f_valid/f_rdata registered high at T+2 for one cycle. The next grant is possible at T+2.
- Pop: same 2-cycle latency on s_valid/s_rdata. s_empty/s_full reflect the updated count at T+1.
- Push: write occurs at T. count/s_full update at T+1. The next grant is possible at T+1.
- Requesters must hold req and data until gnt. After gnt, a requester may drop or re-assert at T+1.
- s_err rises at T+1 after the offending grant and stays high until rst.

## Test plan
- Reset, then push 0x11, 0x22, 0x33: writes to addresses 31, 30, 29; count=3. Pop returns 0x33 on s_valid two cycles after s_gnt, from read address 29.
- f_req and s_push held together from IDLE with prio=0:
  - Fetch is granted first.
  - The push is granted at T+2.
  - A second concurrent pair after a stack grant favours fetch.
- Push 8 entries (s_full=1), then a 9th push: s_gnt=1, mem_we=0, s_err=1 next cycle, count stays 8.
- Pop on empty: s_gnt=1, mem_re=0, s_valid=1 with s_rdata=0x00, s_err=1.
- Fetch f_addr=5 with memory[5]=0xA7: mem_re at T, f_valid with 0xA7 at T+2. Assert rst at T+1: no f_valid, all outputs at reset values.
- s_push=s_pop=1: s_gnt=1, no memory strobe, s_err=1, count unchanged.

Source files
------------

// File: rtl/stack_mem_arbiter.sv
// stack_mem_arbiter
//
// Shares one single-port synchronous memory (one-cycle read latency) between the
// instruction-fetch requester and the operand-stack requester. Owns the stack pointer:
// push/pop are turned into memory addresses, and overflow/underflow are detected.
// When both requesters are pending, they take turns in round-robin order.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   f_req, f_addr             fetch request and address, held until f_gnt
//   f_gnt                     fetch accepted (one-cycle pulse)
//   f_rdata, f_valid          fetched word, two cycles after f_gnt
//   s_push, s_pop, s_wdata    stack request and push data, held until s_gnt
//   s_gnt                     stack request accepted (one-cycle pulse)
//   s_rdata, s_valid          popped word
//   s_full, s_empty           stack occupancy flags
//   s_err                     sticky overflow/underflow/protocol error
//   mem_addr, mem_wdata       memory address and write data
//   mem_we, mem_re            memory write and read strobes
//   mem_rdata                 memory read data, valid the cycle after mem_re

module stack_mem_arbiter #(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned STACK_BASE  = 31,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_valid,
  input  logic              s_push,
  input  logic              s_pop,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_gnt,
  output logic [DATA_W-1:0] s_rdata,
  output logic              s_valid,
  output logic              s_full,
  output logic              s_empty,
  output logic              s_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] F_RD = 2'd1;
  localparam logic [1:0] S_RD = 2'd2;

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STACK_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(STACK_BASE);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              prio_q, prio_d;
  logic              err_q, err_d;
  logic              f_valid_q, f_valid_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_rdata_q, s_rdata_d;

  logic              s_req;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] push_addr;

  assign s_req = s_push | s_pop;
  assign full  = (count_q == CNT_MAX);
  assign empty = (count_q == '0);

  // Stack grows downward: the next free slot sits at BASE - count, the top of
  // stack one above it. Arithmetic wraps modulo 2^ADDR_W.
  assign push_addr = BASE_ADDR - ADDR_W'(count_q);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    prio_d    = prio_q;
    err_d     = err_q;
    f_valid_d = 1'b0;
    f_rdata_d = f_rdata_q;
    s_valid_d = 1'b0;
    s_rdata_d = s_rdata_q;
    f_gnt     = 1'b0;
    s_gnt     = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;

    case (state_q)
      IDLE: begin
        // prio_q == 0 favours fetch when both sides are pending.
        if (f_req && (!s_req || !prio_q)) begin
          f_gnt    = 1'b1;
          mem_re   = 1'b1;
          mem_addr = f_addr;
          prio_d   = 1'b1;
          state_d  = F_RD;
        end else if (s_req) begin
          s_gnt  = 1'b1;
          prio_d = 1'b0;
          if (s_push && s_pop) begin
            err_d = 1'b1;
          end else if (s_push) begin
            if (full) begin
              err_d = 1'b1;
            end else begin
              mem_we    = 1'b1;
              mem_addr  = push_addr;
              mem_wdata = s_wdata;
              count_d   = count_q + CNT_ONE;
            end
          end else begin
            if (empty) begin
              // Underflow still returns a (zero) word so the controller is not left waiting.
              err_d     = 1'b1;
              s_valid_d = 1'b1;
              s_rdata_d = '0;
            end else begin
              mem_re   = 1'b1;
              mem_addr = push_addr + ADDR_W'(1);
              count_d  = count_q - CNT_ONE;
              state_d  = S_RD;
            end
          end
        end
      end
      F_RD: begin
        f_valid_d = 1'b1;
        f_rdata_d = mem_rdata;
        state_d   = IDLE;
      end
      S_RD: begin
        s_valid_d = 1'b1;
        s_rdata_d = mem_rdata;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      prio_q    <= 1'b0;
      err_q     <= 1'b0;
      f_valid_q <= 1'b0;
      f_rdata_q <= '0;
      s_valid_q <= 1'b0;
      s_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      prio_q    <= prio_d;
      err_q     <= err_d;
      f_valid_q <= f_valid_d;
      f_rdata_q <= f_rdata_d;
      s_valid_q <= s_valid_d;
      s_rdata_q <= s_rdata_d;
    end
  end

  assign f_valid = f_valid_q;
  assign f_rdata = f_rdata_q;
  assign s_valid = s_valid_q;
  assign s_rdata = s_rdata_q;
  assign s_full  = full;
  assign s_empty = empty;
  assign s_err   = err_q;

endmodule

// File: tb/tb_stack_mem_arbiter.sv
// Directed bench for stack_mem_arbiter with a small synchronous memory model.
module tb_stack_mem_arbiter;

  logic       clk;
  logic       rst;
  logic       f_req;
  logic [4:0] f_addr;
  logic       f_gnt;
  logic [7:0] f_rdata;
  logic       f_valid;
  logic       s_push;
  logic       s_pop;
  logic [7:0] s_wdata;
  logic       s_gnt;
  logic [7:0] s_rdata;
  logic       s_valid;
  logic       s_full;
  logic       s_empty;
  logic       s_err;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;

  logic [7:0] mem [32];

  int n_checks = 0;
  int n_errors = 0;

  stack_mem_arbiter #(
    .ADDR_W     (5),
    .DATA_W     (8),
    .STACK_BASE (31),
    .STACK_DEPTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_gnt    (f_gnt),
    .f_rdata  (f_rdata),
    .f_valid  (f_valid),
    .s_push   (s_push),
    .s_pop    (s_pop),
    .s_wdata  (s_wdata),
    .s_gnt    (s_gnt),
    .s_rdata  (s_rdata),
    .s_valid  (s_valid),
    .s_full   (s_full),
    .s_empty  (s_empty),
    .s_err    (s_err),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory, one-cycle read latency; preloaded on reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
      mem[5]    <= 8'hA7;
      mem[3]    <= 8'h5C;
      mem_rdata <= 8'h00;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change at the falling edge; combinational outputs are checked 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    f_req = 1'b0; s_push = 1'b0; s_pop = 1'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; f_req = 1'b0; f_addr = 5'd0; s_push = 1'b0; s_pop = 1'b0; s_wdata = 8'h00;
    next_cycle();
    next_cycle();
    settle();
    check_eq("rst f_gnt",   32'(f_gnt),   32'h0);
    check_eq("rst s_gnt",   32'(s_gnt),   32'h0);
    check_eq("rst f_valid", 32'(f_valid), 32'h0);
    check_eq("rst s_valid", 32'(s_valid), 32'h0);
    check_eq("rst s_full",  32'(s_full),  32'h0);
    check_eq("rst s_empty", 32'(s_empty), 32'h1);
    check_eq("rst s_err",   32'(s_err),   32'h0);
    check_eq("rst mem_we",  32'(mem_we),  32'h0);
    check_eq("rst mem_re",  32'(mem_re),  32'h0);
    rst = 1'b0;

    // Three pushes go to 31, 30, 29.
    next_cycle(); s_push = 1'b1; s_wdata = 8'h11; settle();
    check_eq("push1 gnt",  32'(s_gnt),    32'h1);
    check_eq("push1 we",   32'(mem_we),   32'h1);
    check_eq("push1 addr", 32'(mem_addr), 32'd31);
    check_eq("push1 data", 32'(mem_wdata), 32'h11);
    next_cycle(); s_wdata = 8'h22; settle();
    check_eq("push2 addr", 32'(mem_addr), 32'd30);
    check_eq("not empty",  32'(s_empty),  32'h0);
    next_cycle(); s_wdata = 8'h33; settle();
    check_eq("push3 addr", 32'(mem_addr), 32'd29);
    // Pop top (0x33 at 29).
    next_cycle(); s_push = 1'b0; s_pop = 1'b1; settle();
    check_eq("pop gnt",  32'(s_gnt),    32'h1);
    check_eq("pop re",   32'(mem_re),   32'h1);
    check_eq("pop addr", 32'(mem_addr), 32'd29);
    next_cycle(); s_pop = 1'b0; settle();
    check_eq("pop T+1 valid", 32'(s_valid), 32'h0);
    check_eq("pop T+1 gnt",   32'(s_gnt),   32'h0);

    // Concurrent fetch + push with prio=0: fetch first.
    next_cycle(); f_req = 1'b1; f_addr = 5'd5; s_push = 1'b1; s_wdata = 8'h44; settle();
    check_eq("pop T+2 valid", 32'(s_valid), 32'h1);
    check_eq("pop T+2 data",  32'(s_rdata), 32'h33);
    check_eq("pair1 f_gnt",   32'(f_gnt),   32'h1);
    check_eq("pair1 s_gnt",   32'(s_gnt),   32'h0);
    check_eq("pair1 re",      32'(mem_re),  32'h1);
    check_eq("pair1 addr",    32'(mem_addr), 32'd5);
    next_cycle(); f_req = 1'b0; settle();
    check_eq("f_rd no gnt",   32'(s_gnt),   32'h0);
    check_eq("f_rd f_valid",  32'(f_valid), 32'h0);
    next_cycle(); settle();
    check_eq("fetch valid",   32'(f_valid), 32'h1);
    check_eq("fetch data",    32'(f_rdata), 32'hA7);
    check_eq("push T+2 gnt",  32'(s_gnt),   32'h1);
    check_eq("push T+2 addr", 32'(mem_addr), 32'd29);
    check_eq("push T+2 we",   32'(mem_we),  32'h1);

    // Second pair after a stack grant: fetch favoured again.
    next_cycle(); s_push = 1'b0; f_req = 1'b1; f_addr = 5'd3; s_pop = 1'b1; settle();
    check_eq("fetch valid drop", 32'(f_valid), 32'h0);
    check_eq("pair2 f_gnt", 32'(f_gnt), 32'h1);
    check_eq("pair2 s_gnt", 32'(s_gnt), 32'h0);
    next_cycle(); f_req = 1'b0;
    next_cycle(); settle();
    check_eq("fetch2 data", 32'(f_rdata), 32'h5C);
    check_eq("pop2 gnt",    32'(s_gnt),   32'h1);
    check_eq("pop2 addr",   32'(mem_addr), 32'd29);
    next_cycle(); s_pop = 1'b0;
    next_cycle(); settle();
    check_eq("pop2 valid",  32'(s_valid), 32'h1);
    check_eq("pop2 data",   32'(s_rdata), 32'h44);

    // Fill: count is 2, six more pushes reach 8.
    for (int i = 0; i < 6; i++) begin
      next_cycle(); s_push = 1'b1; s_wdata = 8'h60 + 8'(i); settle();
      check_eq("fill addr", 32'(mem_addr), 32'(29 - i));
    end
    next_cycle(); s_wdata = 8'hEE; settle();
    check_eq("full flag",  32'(s_full), 32'h1);
    check_eq("ovf gnt",    32'(s_gnt),  32'h1);
    check_eq("ovf we",     32'(mem_we), 32'h0);
    check_eq("ovf err pre", 32'(s_err), 32'h0);
    next_cycle(); s_push = 1'b0; s_pop = 1'b1; settle();
    check_eq("ovf err",    32'(s_err),    32'h1);
    check_eq("ovf full",   32'(s_full),   32'h1);
    check_eq("pop8 addr",  32'(mem_addr), 32'd24);
    next_cycle(); s_pop = 1'b0; settle();
    check_eq("pop8 full",  32'(s_full),   32'h0);
    next_cycle(); settle();
    check_eq("pop8 data",  32'(s_rdata),  32'h65);

    // Pop on empty.
    do_reset(); settle();
    check_eq("rst2 err",   32'(s_err),   32'h0);
    check_eq("rst2 empty", 32'(s_empty), 32'h1);
    next_cycle(); s_pop = 1'b1; settle();
    check_eq("unf gnt",    32'(s_gnt),  32'h1);
    check_eq("unf re",     32'(mem_re), 32'h0);
    next_cycle(); s_pop = 1'b0; settle();
    check_eq("unf valid",  32'(s_valid), 32'h1);
    check_eq("unf data",   32'(s_rdata), 32'h00);
    check_eq("unf err",    32'(s_err),   32'h1);

    // Reset during a fetch read discards the return.
    do_reset();
    next_cycle(); f_req = 1'b1; f_addr = 5'd5; settle();
    check_eq("rf re",   32'(mem_re),   32'h1);
    check_eq("rf addr", 32'(mem_addr), 32'd5);
    next_cycle(); f_req = 1'b0; rst = 1'b1; settle();
    check_eq("rf rst err",   32'(s_err),   32'h0);
    next_cycle(); settle();
    check_eq("rf no valid",  32'(f_valid), 32'h0);
    check_eq("rf rdata",     32'(f_rdata), 32'h00);
    check_eq("rf empty",     32'(s_empty), 32'h1);
    rst = 1'b0;
    next_cycle(); settle();
    check_eq("rf post valid", 32'(f_valid), 32'h0);

    // Push and pop together.
    next_cycle(); s_push = 1'b1; s_pop = 1'b1; s_wdata = 8'h99; settle();
    check_eq("both gnt", 32'(s_gnt),  32'h1);
    check_eq("both we",  32'(mem_we), 32'h0);
    check_eq("both re",  32'(mem_re), 32'h0);
    next_cycle(); s_pop = 1'b0; settle();
    check_eq("both err",   32'(s_err),    32'h1);
    check_eq("both empty", 32'(s_empty),  32'h1);
    check_eq("both valid", 32'(s_valid),  32'h0);
    check_eq("both addr",  32'(mem_addr), 32'd31);
    next_cycle(); s_push = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
